// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared funct3 size codes, MEM stage FSM encoding and word geometry
package riscv_pipe_pkg;
  localparam int WORD_BYTES = 4;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} mem_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication and load extract/extend.
// Sub-word sizes exist only with MEM_SUBWORD_EN; otherwise every access is a full word.
module mem_lane_align import riscv_pipe_pkg::*; #(
  parameter int N = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [N-1:0]          store_data,
  input  logic [N-1:0]          rdata,
  output logic [WORD_BYTES-1:0] be,
  output logic [N-1:0]          wdata,
  output logic [N-1:0]          load_data,
  output logic                  misaligned
);
`ifdef MEM_SUBWORD_EN
  logic is_b, is_h, sgn;
  logic [15:0] lane;
  assign is_b = funct3 == F3_B || funct3 == F3_BU;
  assign is_h = funct3 == F3_H || funct3 == F3_HU;
  assign sgn = !(funct3 == F3_BU || funct3 == F3_HU);
  assign lane = 16'(rdata >> {offset, 3'b000});
  assign misaligned = is_h ? offset[0] : !is_b && offset != 2'b00;
  assign be = is_b ? 4'b0001 << offset : is_h ? 4'b0011 << offset : 4'b1111;
  assign wdata = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
  assign load_data = is_b ? {{(N-8){sgn & lane[7]}}, lane[7:0]}
                   : is_h ? {{(N-16){sgn & lane[15]}}, lane} : rdata;
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
  assign misaligned = offset != 2'b00;
  assign be = '1;
  assign wdata = store_data;
  assign load_data = rdata;
`endif
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage + MEM/WB register on a valid/ready data-memory port.
// Define MEM_SUBWORD_EN for byte/halfword accesses; otherwise all accesses are words.
module mem_access_stage import riscv_pipe_pkg::*; #(
  parameter int N          = 32,
  parameter int RESET_PC_X = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         ex_valid,
  input  logic [N-1:0] ex_alu_result,
  input  logic [N-1:0] ex_store_data,
  input  logic         ex_mem_read,
  input  logic         ex_mem_write,
  input  logic [2:0]   ex_funct3,
  input  logic         ex_reg_write,
  input  logic [4:0]   ex_rd,
  output logic         stall_o,
  output logic         dmem_req_valid,
  input  logic         dmem_req_ready,
  output logic [N-1:0] dmem_addr,
  output logic         dmem_we,
  output logic [3:0]   dmem_be,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_rsp_valid,
  input  logic [N-1:0] dmem_rdata,
  output logic         wb_valid,
  output logic [N-1:0] wb_result,
  output logic         wb_reg_write,
  output logic [4:0]   wb_rd,
  output logic         misalign_o
);
  mem_state_t state;
  logic [N-1:0] q_addr, q_sdata, addr_sel, lane_wdata, lane_load;
  logic [2:0] q_funct3;
  logic [4:0] q_rd;
  logic [WORD_BYTES-1:0] lane_be;
  logic q_we, q_rw, q_kill;
  logic idle, is_mem, lane_mis, issue, req, we_now, accept, st_done, rsp_done, done;
  logic kill, alu_done, mis_done, fin;
  if (RESET_PC_X != 0) begin : g_reset_pc_x_check
    $error("RESET_PC_X is reserved and must be 0");
  end
  // In flight the request is replayed from the captured copy, so EX/MEM may change freely
  assign idle = state == S_IDLE;
  assign is_mem = ex_valid && (ex_mem_read || ex_mem_write);
  assign addr_sel = idle ? ex_alu_result : q_addr;
  assign we_now = idle ? ex_mem_write : q_we;
  mem_lane_align #(.N(N)) u_align (
    .funct3(idle ? ex_funct3 : q_funct3), .offset(addr_sel[1:0]),
    .store_data(idle ? ex_store_data : q_sdata), .rdata(dmem_rdata),
    .be(lane_be), .wdata(lane_wdata), .load_data(lane_load), .misaligned(lane_mis)
  );
  assign issue = idle && is_mem && !flush && !lane_mis;
  assign req = reset && (issue || state == S_REQ);
  assign accept = req && dmem_req_ready;
  assign st_done = accept && we_now;
  assign rsp_done = state == S_RSP && dmem_rsp_valid;
  assign done = st_done || rsp_done;
  assign kill = flush || (!idle && q_kill);
  assign alu_done = idle && ex_valid && !is_mem;
  assign mis_done = idle && is_mem && lane_mis;
  assign fin = !kill && (alu_done || mis_done || done);
  assign stall_o = reset && (issue || !idle) && !done;
  assign dmem_req_valid = req;
  assign dmem_addr = req ? {addr_sel[N-1:2], 2'b00} : '0;
  assign dmem_we = req && we_now;
  assign dmem_be = req ? lane_be : '0;
  assign dmem_wdata = req ? lane_wdata : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      q_addr <= '0;
      q_sdata <= '0;
      q_funct3 <= '0;
      q_we <= 1'b0;
      q_rw <= 1'b0;
      q_rd <= '0;
      q_kill <= 1'b0;
      wb_valid <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_result <= '0;
      wb_rd <= '0;
      misalign_o <= 1'b0;
    end else begin
      if (issue) begin
        q_addr <= ex_alu_result;
        q_sdata <= ex_store_data;
        q_funct3 <= ex_funct3;
        q_we <= ex_mem_write;
        q_rw <= ex_reg_write && ex_rd != 5'd0;
        q_rd <= ex_rd;
      end
      q_kill <= kill;
      state <= req ? (!accept ? S_REQ : we_now ? S_IDLE : S_RSP)
             : (state == S_RSP && !dmem_rsp_valid) ? S_RSP : S_IDLE;
      wb_valid <= fin;
      wb_reg_write <= fin && (alu_done ? ex_reg_write && ex_rd != 5'd0 : rsp_done && q_rw);
      wb_result <= !fin ? '0 : rsp_done ? lane_load : addr_sel;
      wb_rd <= fin ? (idle ? ex_rd : q_rd) : 5'd0;
      misalign_o <= mis_done && !kill;
    end
  end
endmodule
